midi_rx_parser: RTL and testbench
=================================

# midi_rx_parser

Parametrised MIDI input front end: it takes the raw opto-isolated MIDI serial line and delivers decoded channel-voice messages to the synth voice logic as single-cycle strobes. It combines an oversampled UART receiver with a MIDI message parser. The parser supports running status, interleaved real-time bytes, a runtime channel filter and optional note-on-velocity-0 conversion. It replaces the fixed-rate LED-display receiver and sits between the external I/O pin and the voice allocator.

## Interface
- CLKS_PER_BIT, 1600, clock cycles per MIDI bit (50 MHz / 31250); must be ≥ 4 and even
- SYNC_STAGES, 2, synchroniser flops on midi_data; must be ≥ 2
- VEL0_AS_OFF, 1, when 1, note-on with d2 = 0 is reported as note-off (msg_type 0)

- clck  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- midi_data  in  1  raw serial line, idle high, asynchronous to clck
- chan_mask  in  16  bit n = 1 accepts MIDI channel n; sampled when a message completes
- byte_valid  out  1  one-cycle pulse: byte_out holds a correctly framed byte
- byte_out  out  8  last received byte, held between pulses
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- msg_valid  out  1  one-cycle pulse: msg_* fields hold a new message
- msg_type  out  3  status[6:4]: 0 note-off, 1 note-on, 2 poly AT, 3 CC, 4 program, 5 chan AT, 6 pitch bend
- msg_chan  out  4  status[3:0]
- msg_d1  out  7  first data byte
- msg_d2  out  7  second data byte; 0 for program and channel-AT messages

## Operation
- midi_data passes through SYNC_STAGES flops, all reset to 1; all logic uses the synchronised line `rxs`.
- The receiver FSM has five states: IDLE, START, DATA, STOP, HUNT.
  - Reset and frame errors enter HUNT.
  - HUNT→IDLE after rxs = 1 for CLKS_PER_BIT consecutive cycles; any 0 restarts the count.
  - IDLE→START on the first cycle rxs = 0. Call this cycle T0.
  - START samples at T0 + CLKS_PER_BIT/2. If rxs = 1 it is a glitch: go to IDLE, no output. Otherwise go to DATA.
  - DATA samples bit k (k = 1..8, LSB first) at T0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
  - STOP samples at T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT. If 1: byte_valid and byte_out update, go to IDLE. If 0: frame_err pulses, byte_out is unchanged, the byte is discarded, go to HUNT.
- The parser consumes each byte_valid byte:
  - 0x80–0xEF: latch running status, clear data count.
  - 0xF0–0xF7: clear running status; following data bytes are discarded until the next channel status.
  - 0xF8–0xFF (real-time): ignored completely. Running status and data count are untouched, so these may appear between data bytes.
  - Data byte with no running status: discarded.
  - Data byte with running status: the first data byte is stored as d1.
    - Types 4 and 5 complete on d1, with d2 = 0.
    - All other types complete on the second data byte.
    - On completion the data count returns to 0 and running status is retained.
- On completion, if chan_mask[chan] = 1:
  - msg_valid pulses and msg_* update.
  - If VEL0_AS_OFF = 1 and type = 1 and d2 = 0, msg_type = 0.
- If the channel is masked off, the message is consumed silently and no fields change.
- A frame error does not alter parser state; the half-received message continues with the next good byte.

## Timing
- Reset values: byte_valid 0, byte_out 0x00, frame_err 0, msg_valid 0, msg_type 0, msg_chan 0, msg_d1 0, msg_d2 0. Receiver in HUNT; parser has no running status and data count 0.
- rst_n assertion acts immediately, mid-byte included. The partial byte and partial message are lost.
- Pin to rxs latency is SYNC_STAGES cycles.
- byte_valid / frame_err are asserted at cycle T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1, for exactly one cycle.
- msg_valid is asserted exactly 1 cycle after the byte_valid of the completing byte.
- There is no back-pressure; the consumer must accept msg_valid in the same cycle.
- Outputs are registered and held until the next pulse of their own strobe.
- Back-to-back bytes (a new start bit immediately after a stop sample) are received without loss.

## Test plan
Bench uses CLKS_PER_BIT = 16 and chan_mask = 0xFFFF unless stated.
- Reset, line idle 16+ cycles, send 0x90 0x3C 0x64 -> three byte_valid pulses; one msg_valid with type 1, chan 0, d1 0x3C, d2 0x64; timing per the Timing section.
- Running status with interleaved real-time: send 0x93 0x40 0x7F 0xF8 0x41 0x00 -> two msgs: (1, 3, 0x40, 0x7F), then (0, 3, 0x41, 0); the VEL0_AS_OFF conversion applies to the second.
- Two-byte message and channel filter: chan_mask = 0x0001, send 0xC5 0x10 then 0xC0 0x22 -> single msg (4, 0, 0x22, 0); nothing emitted for channel 5.
- Framing error: send 0x90 with stop bit held low -> frame_err pulse, no byte_valid. Then line high for 16 cycles, then 0x3C 0x64 -> no msg_valid (running status never set).
- Glitch and reset robustness: 4-cycle low pulse on an idle line -> no output. Assert rst_n mid-way through data bit 4 -> all outputs 0. Line held low after reset release -> receiver stays in HUNT until the line is high for 16 cycles.
- SysEx: send 0xB1 0x07 0x50 0xF0 0x01 0x02 0xF7 0x07 0x20 -> one msg (3, 1, 0x07, 0x50) only.

Source files
------------

// File: rtl/midi_rx_parser.sv
// MIDI input front end: oversampled UART receiver feeding a channel-voice message
// parser with running status, real-time pass-through, channel filter and vel-0 handling.
module midi_rx_parser #(
    parameter int CLKS_PER_BIT = 1600,
    parameter int SYNC_STAGES  = 2,
    parameter bit VEL0_AS_OFF  = 1'b1
) (
    input  logic        clck,
    input  logic        rst_n,
    input  logic        midi_data,
    input  logic [15:0] chan_mask,
    output logic        byte_valid,
    output logic [7:0]  byte_out,
    output logic        frame_err,
    output logic        msg_valid,
    output logic [2:0]  msg_type,
    output logic [3:0]  msg_chan,
    output logic [6:0]  msg_d1,
    output logic [6:0]  msg_d2
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HUNT = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_HUNT  = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;

    // Flops preset to 1 so reset looks like an idle line
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], midi_data};
    end
    assign rxs = sync_q[SYNC_STAGES-1];

    // cnt counts cycles since the last sample point (or consecutive highs in HUNT)
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_out   <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (!rxs) cnt <= '0;
                    else if (cnt == CNT_HUNT) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else cnt <= cnt + CNT_ONE;
                end
                ST_IDLE: begin
                    if (!rxs) begin
                        state <= ST_START;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= CNT_ONE;
                        bit_idx <= '0;
                        state   <= rxs ? ST_IDLE : ST_DATA;
                    end else cnt <= cnt + CNT_ONE;
                end
                ST_DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= CNT_ONE;
                        shreg <= {rxs, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else cnt <= cnt + CNT_ONE;
                end
                ST_STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt <= '0;
                        if (rxs) begin
                            byte_valid <= 1'b1;
                            byte_out   <= shreg;
                            state      <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_HUNT;
                        end
                    end else cnt <= cnt + CNT_ONE;
                end
                default: begin
                    state <= ST_HUNT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    logic       run_valid;
    logic [6:0] run_status;
    logic       have_d1;
    logic [6:0] d1_q;
    logic [2:0] cur_type;
    logic       short_msg;
    logic       complete;
    logic [6:0] c_d1;
    logic [6:0] c_d2;

    assign cur_type  = run_status[6:4];
    assign short_msg = (cur_type == 3'd4) || (cur_type == 3'd5);
    assign complete  = byte_valid && !byte_out[7] && run_valid && (have_d1 || short_msg);
    assign c_d1      = have_d1 ? d1_q : byte_out[6:0];
    assign c_d2      = have_d1 ? byte_out[6:0] : 7'd0;

    // Real-time bytes (F8-FF) fall through every branch and leave parser state alone
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            run_valid  <= 1'b0;
            run_status <= '0;
            have_d1    <= 1'b0;
            d1_q       <= '0;
            msg_valid  <= 1'b0;
            msg_type   <= '0;
            msg_chan   <= '0;
            msg_d1     <= '0;
            msg_d2     <= '0;
        end else begin
            msg_valid <= 1'b0;
            if (byte_valid) begin
                if (byte_out[7]) begin
                    if (byte_out[7:4] != 4'hF) begin
                        run_valid  <= 1'b1;
                        run_status <= byte_out[6:0];
                        have_d1    <= 1'b0;
                    end else if (!byte_out[3]) begin
                        run_valid <= 1'b0;
                        have_d1   <= 1'b0;
                    end
                end else if (complete) begin
                    have_d1 <= 1'b0;
                    if (chan_mask[run_status[3:0]]) begin
                        msg_valid <= 1'b1;
                        msg_type  <= (VEL0_AS_OFF && cur_type == 3'd1 && c_d2 == 7'd0) ? 3'd0 : cur_type;
                        msg_chan  <= run_status[3:0];
                        msg_d1    <= c_d1;
                        msg_d2    <= c_d2;
                    end
                end else if (run_valid) begin
                    d1_q    <= byte_out[6:0];
                    have_d1 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Scoreboard bench for midi_rx_parser: tasks push expected bytes/messages, a negedge
// monitor pops and compares them as the DUT strobes its outputs.
`timescale 1ns/1ps
module tb_midi_rx_parser;

    localparam int C  = 16;
    localparam int H  = C / 2;
    localparam int SS = 2;

    typedef struct packed {
        logic [2:0] t;
        logic [3:0] c;
        logic [6:0] d1;
        logic [6:0] d2;
    } msg_t;

    logic        clck = 1'b0;
    logic        rst_n = 1'b0;
    logic        midi_data = 1'b1;
    logic [15:0] chan_mask = 16'hFFFF;
    logic        byte_valid, frame_err, msg_valid;
    logic [7:0]  byte_out;
    logic [2:0]  msg_type;
    logic [3:0]  msg_chan;
    logic [6:0]  msg_d1, msg_d2;

    midi_rx_parser #(.CLKS_PER_BIT(C), .SYNC_STAGES(SS), .VEL0_AS_OFF(1'b1)) dut (
        .clck(clck), .rst_n(rst_n), .midi_data(midi_data), .chan_mask(chan_mask),
        .byte_valid(byte_valid), .byte_out(byte_out), .frame_err(frame_err),
        .msg_valid(msg_valid), .msg_type(msg_type), .msg_chan(msg_chan),
        .msg_d1(msg_d1), .msg_d2(msg_d2)
    );

    always #5 clck = ~clck;

    int cyc = 0;
    always @(posedge clck) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_bytes[$];
    msg_t       exp_msgs[$];
    int         exp_fe = 0;
    int         bv_cyc[$];
    int         mv_cyc[$];
    logic [7:0] mon_eb;
    msg_t       mon_em, mon_got;

    always @(negedge clck) begin
        if (rst_n) begin
            if (byte_valid) begin
                bv_cyc.push_back(cyc);
                checks++;
                if (exp_bytes.size() == 0) begin
                    errors++;
                    $display("FAIL byte_valid: unexpected byte %h", byte_out);
                end else begin
                    mon_eb = exp_bytes.pop_front();
                    if (byte_out !== mon_eb) begin
                        errors++;
                        $display("FAIL byte_out: got %h want %h", byte_out, mon_eb);
                    end
                end
            end
            if (frame_err) begin
                checks++;
                if (exp_fe == 0) begin
                    errors++;
                    $display("FAIL frame_err: unexpected pulse");
                end else exp_fe--;
            end
            if (msg_valid) begin
                mv_cyc.push_back(cyc);
                checks++;
                mon_got = {msg_type, msg_chan, msg_d1, msg_d2};
                if (exp_msgs.size() == 0) begin
                    errors++;
                    $display("FAIL msg_valid: unexpected msg t=%0d c=%0d d1=%h d2=%h",
                             msg_type, msg_chan, msg_d1, msg_d2);
                end else begin
                    mon_em = exp_msgs.pop_front();
                    if (mon_got !== mon_em) begin
                        errors++;
                        $display("FAIL msg: got t=%0d c=%0d d1=%h d2=%h want t=%0d c=%0d d1=%h d2=%h",
                                 mon_got.t, mon_got.c, mon_got.d1, mon_got.d2,
                                 mon_em.t, mon_em.c, mon_em.d1, mon_em.d2);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        midi_data = 1'b1;
        repeat (n) @(posedge clck);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
        midi_data = 1'b0;
        repeat (C) @(posedge clck);
        #1;
        for (int i = 0; i < 8; i++) begin
            midi_data = b[i];
            repeat (C) @(posedge clck);
            #1;
        end
        midi_data = stop_lvl;
        repeat (C) @(posedge clck);
        #1;
        midi_data = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clck);
        #1;
        checks++;
        if ({byte_valid, frame_err, msg_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 000", {byte_valid, frame_err, msg_valid});
        end
        checks++;
        if ({byte_out, msg_type, msg_chan, msg_d1, msg_d2} !== 29'd0) begin
            errors++;
            $display("FAIL reset_fields: got %h want 0", {byte_out, msg_type, msg_chan, msg_d1, msg_d2});
        end
        rst_n = 1'b1;
        idle(20);
    endtask

    task automatic test_basic();
        int t0;
        bv_cyc.delete();
        mv_cyc.delete();
        exp_bytes.push_back(8'h90); exp_bytes.push_back(8'h3C); exp_bytes.push_back(8'h64);
        exp_msgs.push_back(msg_t'({3'd1, 4'd0, 7'h3C, 7'h64}));
        t0 = cyc;
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        idle(20);
        checks++;
        if (bv_cyc.size() != 3 || bv_cyc[0] != t0 + SS + 1 + H + 9 * C) begin
            errors++;
            $display("FAIL basic_byte_timing: got %0d pulses first at %0d, want 3 at %0d",
                     bv_cyc.size(), (bv_cyc.size() > 0) ? bv_cyc[0] - t0 : -1, SS + 1 + H + 9 * C);
        end
        checks++;
        if (bv_cyc.size() != 3 || bv_cyc[1] - bv_cyc[0] != 10 * C || bv_cyc[2] - bv_cyc[1] != 10 * C) begin
            errors++;
            $display("FAIL basic_back_to_back: pulse spacing wrong, want %0d cycles", 10 * C);
        end
        checks++;
        if (mv_cyc.size() != 1 || bv_cyc.size() != 3 || mv_cyc[0] != bv_cyc[2] + 1) begin
            errors++;
            $display("FAIL basic_msg_timing: got %0d msgs, want 1 msg one cycle after last byte", mv_cyc.size());
        end
        checks++;
        if (exp_bytes.size() != 0 || exp_msgs.size() != 0) begin
            errors++;
            $display("FAIL basic_pending: got %0d bytes %0d msgs outstanding, want 0", exp_bytes.size(), exp_msgs.size());
        end
    endtask

    task automatic test_running();
        logic [7:0] seq [6] = '{8'h93, 8'h40, 8'h7F, 8'hF8, 8'h41, 8'h00};
        foreach (seq[i]) exp_bytes.push_back(seq[i]);
        exp_msgs.push_back(msg_t'({3'd1, 4'd3, 7'h40, 7'h7F}));
        exp_msgs.push_back(msg_t'({3'd0, 4'd3, 7'h41, 7'h00}));
        foreach (seq[i]) send_byte(seq[i], 1'b1);
        idle(20);
        checks++;
        if (exp_bytes.size() != 0 || exp_msgs.size() != 0) begin
            errors++;
            $display("FAIL running_pending: got %0d bytes %0d msgs outstanding, want 0", exp_bytes.size(), exp_msgs.size());
        end
    endtask

    task automatic test_filter();
        chan_mask = 16'h0001;
        exp_bytes.push_back(8'hC5); exp_bytes.push_back(8'h10);
        send_byte(8'hC5, 1'b1);
        send_byte(8'h10, 1'b1);
        idle(20);
        checks++;
        if (msg_chan !== 4'd3 || msg_d1 !== 7'h41) begin
            errors++;
            $display("FAIL filter_hold: got chan %0d d1 %h want chan 3 d1 41", msg_chan, msg_d1);
        end
        exp_bytes.push_back(8'hC0); exp_bytes.push_back(8'h22);
        exp_msgs.push_back(msg_t'({3'd4, 4'd0, 7'h22, 7'h00}));
        send_byte(8'hC0, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(20);
        chan_mask = 16'hFFFF;
        checks++;
        if (exp_bytes.size() != 0 || exp_msgs.size() != 0) begin
            errors++;
            $display("FAIL filter_pending: got %0d bytes %0d msgs outstanding, want 0", exp_bytes.size(), exp_msgs.size());
        end
    endtask

    task automatic test_sysex();
        logic [7:0] seq [9] = '{8'hB1, 8'h07, 8'h50, 8'hF0, 8'h01, 8'h02, 8'hF7, 8'h07, 8'h20};
        foreach (seq[i]) exp_bytes.push_back(seq[i]);
        exp_msgs.push_back(msg_t'({3'd3, 4'd1, 7'h07, 7'h50}));
        foreach (seq[i]) send_byte(seq[i], 1'b1);
        idle(20);
        checks++;
        if (exp_bytes.size() != 0 || exp_msgs.size() != 0) begin
            errors++;
            $display("FAIL sysex_pending: got %0d bytes %0d msgs outstanding, want 0", exp_bytes.size(), exp_msgs.size());
        end
    endtask

    task automatic test_glitch_reset();
        logic [7:0] b = 8'hA5;
        midi_data = 1'b0;
        repeat (4) @(posedge clck);
        #1;
        idle(200);
        // partial byte, reset lands in the middle of data bit 4
        midi_data = 1'b0;
        repeat (C) @(posedge clck);
        #1;
        for (int i = 0; i < 5; i++) begin
            midi_data = b[i];
            repeat ((i == 4) ? H : C) @(posedge clck);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({byte_valid, byte_out, frame_err, msg_valid, msg_type, msg_chan, msg_d1, msg_d2} !== 32'd0) begin
            errors++;
            $display("FAIL midbyte_reset: got %h want 0",
                     {byte_valid, byte_out, frame_err, msg_valid, msg_type, msg_chan, msg_d1, msg_d2});
        end
        midi_data = 1'b0;
        repeat (3) @(posedge clck);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clck);
        #1;
        idle(C);
        exp_bytes.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        idle(20);
        checks++;
        if (exp_bytes.size() != 0 || exp_msgs.size() != 0 || exp_fe != 0) begin
            errors++;
            $display("FAIL hunt_recover: got %0d bytes outstanding, want 0", exp_bytes.size());
        end
    endtask

    task automatic test_frame();
        rst_n = 1'b0;
        @(posedge clck);
        #1;
        rst_n = 1'b1;
        idle(20);
        exp_fe = 1;
        send_byte(8'h90, 1'b0);
        // broken high runs: neither reaches a full bit of idle, so the 0x00 is missed
        idle(12);
        midi_data = 1'b0;
        repeat (4) @(posedge clck);
        #1;
        idle(12);
        send_byte(8'h00, 1'b1);
        idle(20);
        checks++;
        if (exp_fe != 0 || byte_out !== 8'h00) begin
            errors++;
            $display("FAIL frame_err_byte: got fe_left %0d byte_out %h want 0 and 00", exp_fe, byte_out);
        end
        exp_bytes.push_back(8'h3C); exp_bytes.push_back(8'h64);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        idle(20);
        checks++;
        if (exp_bytes.size() != 0 || exp_msgs.size() != 0 || msg_d1 !== 7'h00) begin
            errors++;
            $display("FAIL frame_no_status: got %0d bytes outstanding d1 %h want 0 and 00", exp_bytes.size(), msg_d1);
        end
    endtask

    initial begin
        @(posedge clck);
        #1;
        test_reset();
        test_basic();
        test_running();
        test_filter();
        test_sysex();
        test_glitch_reset();
        test_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
